// File: rtl/vga_timing_gen_if.sv
// Scan-side bundle between vga_timing_gen and its consumer.
//   master (generator): takes pix_en, swap_req; drives position_x/y, draw,
//                       hsync, vsync, vblank, line_start, frame_start, swap_ack
//                       and, with VGA_FRAME_COUNT_EN defined, frame_count.
//   slave  (consumer) : the mirror image.
// Optional feature macro: VGA_FRAME_COUNT_EN adds the 16-bit frame_count signal.
interface vga_timing_gen_if;
    logic       pix_en;
    logic       swap_req;
    logic [9:0] position_x;
    logic [9:0] position_y;
    logic       draw;
    logic       hsync;
    logic       vsync;
    logic       vblank;
    logic       line_start;
    logic       frame_start;
    logic       swap_ack;
`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] frame_count;
`endif

    modport master (
`ifdef VGA_FRAME_COUNT_EN
        output frame_count,
`endif
        input  pix_en, swap_req,
        output position_x, position_y, draw, hsync, vsync, vblank,
        output line_start, frame_start, swap_ack
    );

    modport slave (
`ifdef VGA_FRAME_COUNT_EN
        input  frame_count,
`endif
        output pix_en, swap_req,
        input  position_x, position_y, draw, hsync, vsync, vblank,
        input  line_start, frame_start, swap_ack
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster scan generator: h/v counters, active-area position and draw flag,
// hsync/vsync (optionally delayed to match downstream pixel latency) and a
// swap handshake that only grants on vblank entry.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset (priority over pix_en)
//   bus  - vga_timing_gen_if.master: pix_en/swap_req in, scan outputs out
// Optional feature macro: VGA_FRAME_COUNT_EN adds bus.frame_count, a 16-bit
// count of frame_start pulses since reset.
// H_TOTAL and V_TOTAL must both be <= 1024 (10-bit counters).
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter bit          SYNC_POL   = 1'b0,
    parameter int unsigned PIPE_DELAY = 0
) (
    input logic              clk,
    input logic              rst,
    vga_timing_gen_if.master bus
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;
    logic       active;
    logic       hs_lvl, vs_lvl;
    logic       at_origin, at_vbl_entry;

    logic [9:0] pos_x_q, pos_y_q;
    logic       draw_q, vblank_q, line_start_q, frame_start_q, swap_ack_q;
    // Stage 0 is the registered sync; stages 1..PIPE_DELAY are the extra delay.
    logic [PIPE_DELAY:0] hs_pipe_q, vs_pipe_q;

    always_comb begin
        active       = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        hs_lvl       = (h_cnt_q >= HS_FIRST && h_cnt_q <= HS_LAST) ? SYNC_POL : ~SYNC_POL;
        vs_lvl       = (v_cnt_q >= VS_FIRST && v_cnt_q <= VS_LAST) ? SYNC_POL : ~SYNC_POL;
        at_origin    = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
        at_vbl_entry = (h_cnt_q == 10'd0) && (v_cnt_q == V_ACT);

        h_cnt_d = h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = 10'd0;
            v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q       <= 10'd0;
            v_cnt_q       <= 10'd0;
            pos_x_q       <= 10'd0;
            pos_y_q       <= 10'd0;
            draw_q        <= 1'b0;
            vblank_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            swap_ack_q    <= 1'b0;
            hs_pipe_q     <= {(PIPE_DELAY + 1){~SYNC_POL}};
            vs_pipe_q     <= {(PIPE_DELAY + 1){~SYNC_POL}};
        end else begin
            // Pulses are single-cycle even when pix_en is slower than clk.
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            swap_ack_q    <= 1'b0;
            if (bus.pix_en) begin
                h_cnt_q       <= h_cnt_d;
                v_cnt_q       <= v_cnt_d;
                pos_x_q       <= active ? h_cnt_q : 10'd0;
                pos_y_q       <= active ? v_cnt_q : 10'd0;
                draw_q        <= active;
                vblank_q      <= (v_cnt_q >= V_ACT);
                line_start_q  <= (h_cnt_q == 10'd0);
                frame_start_q <= at_origin;
                swap_ack_q    <= at_vbl_entry && bus.swap_req;
                hs_pipe_q[0]  <= hs_lvl;
                vs_pipe_q[0]  <= vs_lvl;
                for (int i = 1; i <= PIPE_DELAY; i++) begin
                    hs_pipe_q[i] <= hs_pipe_q[i-1];
                    vs_pipe_q[i] <= vs_pipe_q[i-1];
                end
            end
        end
    end

    assign bus.position_x  = pos_x_q;
    assign bus.position_y  = pos_y_q;
    assign bus.draw        = draw_q;
    assign bus.vblank      = vblank_q;
    assign bus.line_start  = line_start_q;
    assign bus.frame_start = frame_start_q;
    assign bus.swap_ack    = swap_ack_q;
    assign bus.hsync       = hs_pipe_q[PIPE_DELAY];
    assign bus.vsync       = vs_pipe_q[PIPE_DELAY];

`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] frame_count_q;

    // Counts in the same edge that registers frame_start, so the first frame reads 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_count_q <= 16'd0;
        end else if (bus.pix_en && at_origin) begin
            frame_count_q <= frame_count_q + 16'd1;
        end
    end

    assign bus.frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a reduced raster (16x11 total, 8x6
// active) so whole frames fit in a short run. A second instance uses
// PIPE_DELAY=2 and its syncs must lag the first by two pix_en ticks.
module tb_vga_timing_gen;
    localparam int HA = 8, HF = 2, HS = 3, HB = 3;
    localparam int VA = 6, VF = 1, VS = 2, VB = 2;
    localparam int HT = 16, VT = 11, FT = 176;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vga_timing_gen_if bus_a ();
    vga_timing_gen_if bus_b ();

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b0), .PIPE_DELAY(0)
    ) u_dut_a (
        .clk(clk),
        .rst(rst),
        .bus(bus_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b0), .PIPE_DELAY(2)
    ) u_dut_b (
        .clk(clk),
        .rst(rst),
        .bus(bus_b)
    );

    int checks = 0;
    int errors = 0;
    int cur_t  = 0;
    bit sched_on;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0d observed=%0d expected=%0d", tag, cur_t, obs, exp);
        end
    endtask

    // Swap request: raised at line 2 until the ack at (0,6); raised again at
    // line 9 (mid-vblank) and held through two vblank entries.
    function automatic bit req_at(int t);
        return sched_on && ((t >= 32 && t <= 96) || (t >= 144 && t <= 448));
    endfunction

    function automatic bit hs_exp(int t);
        int h;
        if (t < 0) return 1'b1;
        h = t % HT;
        return !(h >= 10 && h <= 12);
    endfunction

    function automatic bit vs_exp(int t);
        int v;
        if (t < 0) return 1'b1;
        v = (t / HT) % VT;
        return !(v >= 7 && v <= 8);
    endfunction

    task automatic cycle(input bit r, input bit en, input bit req);
        @(negedge clk);
        rst            = r;
        bus_a.pix_en   = en;
        bus_b.pix_en   = en;
        bus_a.swap_req = req;
        bus_b.swap_req = req;
        @(posedge clk);
        #1;
    endtask

    // t is the 0-based pix_en tick since reset whose outputs are visible now.
    task automatic check_all(input int t, input bit idle);
        int h, v;
        bit act;
        cur_t = t;
        h   = t % HT;
        v   = (t / HT) % VT;
        act = (h < HA) && (v < VA);
        chk("draw", bus_a.draw, act);
        chk("pos_x", bus_a.position_x, act ? h : 0);
        chk("pos_y", bus_a.position_y, act ? v : 0);
        chk("hsync", bus_a.hsync, hs_exp(t));
        chk("vsync", bus_a.vsync, vs_exp(t));
        chk("vblank", bus_a.vblank, v >= VA);
        chk("line_start", bus_a.line_start, !idle && h == 0);
        chk("frame_start", bus_a.frame_start, !idle && h == 0 && v == 0);
        chk("swap_ack", bus_a.swap_ack, !idle && req_at(t) && h == 0 && v == VA);
        chk("draw_b", bus_b.draw, act);
        chk("hsync_d2", bus_b.hsync, hs_exp(t - 2));
        chk("vsync_d2", bus_b.vsync, vs_exp(t - 2));
`ifdef VGA_FRAME_COUNT_EN
        chk("frame_count", bus_a.frame_count, (t / FT + 1) & 32'hffff);
`endif
    endtask

    task automatic check_reset();
        chk("rst_draw", bus_a.draw, 0);
        chk("rst_pos_x", bus_a.position_x, 0);
        chk("rst_pos_y", bus_a.position_y, 0);
        chk("rst_hsync", bus_a.hsync, 1);
        chk("rst_vsync", bus_a.vsync, 1);
        chk("rst_vblank", bus_a.vblank, 0);
        chk("rst_line_start", bus_a.line_start, 0);
        chk("rst_frame_start", bus_a.frame_start, 0);
        chk("rst_swap_ack", bus_a.swap_ack, 0);
        chk("rst_hsync_b", bus_b.hsync, 1);
        chk("rst_vsync_b", bus_b.vsync, 1);
`ifdef VGA_FRAME_COUNT_EN
        chk("rst_frame_count", bus_a.frame_count, 0);
`endif
    endtask

    initial begin
        rst      = 1'b1;
        sched_on = 1'b1;
        bus_a.pix_en = 1'b0; bus_b.pix_en = 1'b0;
        bus_a.swap_req = 1'b0; bus_b.swap_req = 1'b0;

        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);  // rst must win over pix_en
        check_reset();

        cycle(1'b0, 1'b0, 1'b0);
        chk("rel_idle_draw", bus_a.draw, 0);
        chk("rel_idle_frame_start", bus_a.frame_start, 0);

        // Frame 0 at half rate: every tick preceded by an idle cycle.
        for (int t = 0; t < FT; t++) begin
            if (t > 0) begin
                cycle(1'b0, 1'b0, req_at(t));
                check_all(t - 1, 1'b1);
            end
            cycle(1'b0, 1'b1, req_at(t));
            check_all(t, 1'b0);
            if (t == 0) begin
                chk("t1_draw", bus_a.draw, 1);
                chk("t1_pos_x", bus_a.position_x, 0);
                chk("t1_pos_y", bus_a.position_y, 0);
                chk("t1_frame_start", bus_a.frame_start, 1);
                chk("t1_line_start", bus_a.line_start, 1);
            end
            if (t == 7)   chk("last_col", bus_a.position_x, 7);
            if (t == 8) begin
                chk("past_active_draw", bus_a.draw, 0);
                chk("past_active_x", bus_a.position_x, 0);
            end
            if (t == 9)   chk("hs_before", bus_a.hsync, 1);
            if (t == 10)  chk("hs_first", bus_a.hsync, 0);
            if (t == 12)  chk("hs_last", bus_a.hsync, 0);
            if (t == 13)  chk("hs_after", bus_a.hsync, 1);
            if (t == 16)  chk("line1_start", bus_a.line_start, 1);
            if (t == 95)  chk("vblank_before", bus_a.vblank, 0);
            if (t == 96) begin
                chk("vblank_rise", bus_a.vblank, 1);
                chk("ack_first", bus_a.swap_ack, 1);
            end
            if (t == 111) chk("vs_before", bus_a.vsync, 1);
            if (t == 112) chk("vs_first", bus_a.vsync, 0);
            if (t == 143) chk("vs_last", bus_a.vsync, 0);
            if (t == 144) chk("vs_after", bus_a.vsync, 1);
        end

        // Full rate through frames 1..3 up to (5,3) of frame 3.
        for (int t = FT; t <= 581; t++) begin
            cycle(1'b0, 1'b1, req_at(t));
            check_all(t, 1'b0);
            if (t == 176) chk("frame1_start", bus_a.frame_start, 1);
            if (t == 272) chk("ack_next_frame", bus_a.swap_ack, 1);
            if (t == 448) chk("ack_repeat", bus_a.swap_ack, 1);
            if (t == 581) begin
                chk("mid_pos_x", bus_a.position_x, 5);
                chk("mid_pos_y", bus_a.position_y, 3);
            end
        end

        // Mid-frame reset.
        sched_on = 1'b0;
        cycle(1'b1, 1'b1, 1'b0);
        check_reset();
        cycle(1'b0, 1'b0, 1'b0);
        chk("rel2_idle_draw", bus_a.draw, 0);
        for (int t = 0; t <= 40; t++) begin
            cycle(1'b0, 1'b1, 1'b0);
            check_all(t, 1'b0);
            if (t == 0) begin
                chk("restart_frame_start", bus_a.frame_start, 1);
                chk("restart_draw", bus_a.draw, 1);
                chk("restart_pos_x", bus_a.position_x, 0);
                chk("restart_pos_y", bus_a.position_y, 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
